fifo_rd_unload: RTL
===================

# fifo_rd_unload

Read-domain end of the team's asynchronous FIFO. It synchronises the write-side Gray pointer into `r_clk`, maintains the binary and Gray read pointers, drives the memory read address and computes empty and occupancy. It unloads entries into a registered first-word-fall-through output stage with a valid/ready handshake. It sits between the dual-port FIFO memory and the read-domain consumer, for example the UART TX feeder or the register-file response path.

## Interface
- `ADDR_W`, default 3: memory address width; depth = 2^ADDR_W.
- `PTR_W`, default `ADDR_W+1`: pointer width, including the wrap bit.
- `DATA_W`, default 8: data width.

Ports (name, direction, width, meaning):
- `r_clk` in 1: read-domain clock.
- `rrst_n` in 1: reset; asynchronous, active-low; clock `r_clk`.
- `w_gray_ptr` in PTR_W: write Gray pointer, registered in the write domain and not yet synchronised.
- `mem_rdata` in DATA_W: asynchronous-read memory data at `raddr`.
- `raddr` out ADDR_W: memory read address = `rptr[ADDR_W-1:0]`.
- `r_gray_ptr` out PTR_W: registered read Gray pointer, sent to the write-domain synchroniser.
- `rempty` out 1: FIFO memory empty. The output stage is not counted.
- `r_level` out PTR_W: entries in memory as seen by the read domain.
- `out_valid` out 1: `out_data` holds a valid word.
- `out_data` out DATA_W: registered output word.
- `out_ready` in 1: consumer accepts `out_data` this cycle.

## Operation
- Synchroniser: 2-flop chain `rq1_wptr` → `rq2_wptr`. It is reset to 0 and samples `w_gray_ptr` on every `r_clk` edge.
- Empty: `rempty = (r_gray_ptr == rq2_wptr)`, combinational.
- Write-pointer binary: `rq2_bin = gray2bin(rq2_wptr)`, where bit i is the XOR of bits PTR_W-1..i.
- Level: `r_level = rq2_bin - rptr`, modulo 2^PTR_W. The range is 0..2^ADDR_W.
- Pop condition: `pop = !rempty && (!out_valid || out_ready)`.
- On `pop`:
  - `out_data <= mem_rdata`, `out_valid <= 1`.
  - `rptr <= rptr + 1`.
  - `r_gray_ptr <= bin2gray(rptr + 1)`, where `bin2gray(x) = x ^ (x >> 1)`.
- No `pop` but `out_ready`: `out_valid <= 0`, and `out_data` holds its value.
- No `pop` and no `out_ready`: all state holds.
- `rptr` and `r_gray_ptr` always change in the same cycle. `r_gray_ptr` changes by exactly one bit per pop.
- Wrap-around: the pointers roll over from 2^PTR_W-1 to 0 with no special case. `raddr` wraps every 2^ADDR_W pops.
- Simultaneous consume and refill: `out_valid` && `out_ready` && !`rempty` gives a back-to-back pop. `out_valid` stays 1 and `out_data` takes the new word, so throughput is 1 word per cycle.
- Empty while the consumer stalls: no pop occurs and `out_data` is held.
- Underflow is impossible by construction. The pointers never advance while `rempty` is high.

## Timing
- Reset values: `rptr`, `r_gray_ptr`, `rq1_wptr` and `rq2_wptr` are 0. `raddr` = 0, `rempty` = 1, `r_level` = 0, `out_valid` = 0, `out_data` = 0.
- Latency from a `w_gray_ptr` change to `out_valid`, with the output stage empty:
  - Edge 1: `rq1_wptr` captures the change.
  - Edge 2: `rq2_wptr` updates, and `rempty` falls combinationally.
  - Edge 3: pop; `out_valid` rises.
- `out_data` is stable for as long as `out_valid` && !`out_ready`.
- Reset asserted mid-operation: all state returns to the reset values immediately (asynchronously). A word held in the output stage is discarded.
- Reset release is synchronous to `r_clk`; the deassertion synchroniser is outside this block.

## Structure
- Shared package `fifo_pkg` holds:
  - default widths `FIFO_ADDR_W = 3` and `FIFO_DATA_W = 8`;
  - functions `bin2gray` and `gray2bin`, parameterised by PTR_W.
- One sub-module, `fifo_ptr_sync`: a PTR_W-bit 2-flop synchroniser with asynchronous active-low reset. The write side reuses it.

## Test plan
- Reset, then idle, with `w_gray_ptr` = 0: `rempty` = 1, `out_valid` = 0, `raddr` = 0, `r_level` = 0.
- Write pointer advanced to Gray 0001, `mem_rdata` = 8'hA5, `out_ready` = 0:
  - `rempty` falls after edge 2;
  - `out_valid` = 1 and `out_data` = A5 after edge 3;
  - `r_gray_ptr` = 0001, `rempty` = 1.
- `w_gray_ptr` = Gray(5) = 0111, `out_ready` held 1: five consecutive pops, one per cycle, at `raddr` 0..4. `r_gray_ptr` ends at 0111 and `r_level` ends at 0.
- Stall: 3 entries present, `out_ready` = 0 for 4 cycles:
  - exactly one pop, and `out_data` is held;
  - `r_level` = 2;
  - `out_ready` = 1 then drains the remaining entries at one per cycle.
- Wrap: drive 20 writes and 20 reads through the FIFO. `raddr` sequence 7 → 0 and `r_gray_ptr` sequence 1000 → 0000 are observed, data order is preserved, and each `r_gray_ptr` step changes one bit.
- Drop `rrst_n` while `out_valid` = 1 and `r_level` = 3: outputs immediately take the reset values. After release there is no `out_valid` until `w_gray_ptr` differs from 0.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared definitions for both clock-domain halves of the asynchronous FIFO:
// default widths and the binary/Gray pointer conversions.
package fifo_pkg;

    localparam int FIFO_ADDR_W    = 3;
    localparam int FIFO_DATA_W    = 8;
    localparam int FIFO_PTR_MAX_W = 32;

    typedef logic [FIFO_PTR_MAX_W-1:0] fifo_ptr_t;

    // Callers zero-extend a PTR_W-bit pointer into fifo_ptr_t and keep the low
    // PTR_W bits of the result; leading zeros do not disturb either conversion.
    function automatic fifo_ptr_t bin2gray(input fifo_ptr_t bin);
        return bin ^ (bin >> 1);
    endfunction

    function automatic fifo_ptr_t gray2bin(input fifo_ptr_t gray);
        fifo_ptr_t bin;
        bin[FIFO_PTR_MAX_W-1] = gray[FIFO_PTR_MAX_W-1];
        for (int i = FIFO_PTR_MAX_W - 2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

endpackage

// File: rtl/fifo_rd_unload_if.sv
// Signals between the FIFO read-domain unloader (master) and its surroundings:
// memory read port, pointer exchange and the consumer handshake.
interface fifo_rd_unload_if
    import fifo_pkg::*;
#(
    parameter int ADDR_W = FIFO_ADDR_W,
    parameter int PTR_W  = ADDR_W + 1,
    parameter int DATA_W = FIFO_DATA_W
);

    logic [PTR_W-1:0]  w_gray_ptr;
    logic [DATA_W-1:0] mem_rdata;
    logic [ADDR_W-1:0] raddr;
    logic [PTR_W-1:0]  r_gray_ptr;
    logic              rempty;
    logic [PTR_W-1:0]  r_level;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_ready;

    modport master (
        input  w_gray_ptr, mem_rdata, out_ready,
        output raddr, r_gray_ptr, rempty, r_level, out_valid, out_data
    );

    modport slave (
        output w_gray_ptr, mem_rdata, out_ready,
        input  raddr, r_gray_ptr, rempty, r_level, out_valid, out_data
    );

endinterface

// File: rtl/fifo_ptr_sync.sv
// Two-flop synchroniser for a Gray-coded FIFO pointer crossing into clk.
// Shared by the read and write halves of the FIFO.
module fifo_ptr_sync #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta_q, meta_d;
    logic [W-1:0] sync_q, sync_d;

    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            // NOTE: non-blocking so sync_q takes the old meta_q, giving two real stages.
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/fifo_rd_unload.sv
// Read-domain end of the asynchronous FIFO: read pointers, empty/level, and a
// registered first-word-fall-through output stage with valid/ready.
module fifo_rd_unload
    import fifo_pkg::*;
#(
    parameter int ADDR_W = FIFO_ADDR_W,
    parameter int PTR_W  = ADDR_W + 1,
    parameter int DATA_W = FIFO_DATA_W
) (
    input  logic              r_clk,
    input  logic              rrst_n,
    fifo_rd_unload_if.master  bus
);

    logic [PTR_W-1:0]  rq2_wptr;
    logic [PTR_W-1:0]  rq2_bin;
    logic [PTR_W-1:0]  rptr_inc;
    logic              rempty;
    logic              pop;

    logic [PTR_W-1:0]  rptr_q, rptr_d;
    logic [PTR_W-1:0]  r_gray_q, r_gray_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;

    fifo_ptr_sync #(.W(PTR_W)) u_wptr_sync (
        .clk   (r_clk),
        .rst_n (rrst_n),
        .d     (bus.w_gray_ptr),
        .q     (rq2_wptr)
    );

    always_comb begin
        rq2_bin  = PTR_W'(gray2bin(fifo_ptr_t'(rq2_wptr)));
        rptr_inc = rptr_q + PTR_W'(1);
        rempty   = (r_gray_q == rq2_wptr);
        // A word moves out of memory when the stage is empty or being drained.
        pop      = !rempty && (!out_valid_q || bus.out_ready);

        // NOTE: every next-state value gets a hold default first, so no latch is inferred.
        rptr_d      = rptr_q;
        r_gray_d    = r_gray_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;

        if (pop) begin
            rptr_d      = rptr_inc;
            r_gray_d    = PTR_W'(bin2gray(fifo_ptr_t'(rptr_inc)));
            out_valid_d = 1'b1;
            out_data_d  = bus.mem_rdata;
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge r_clk or negedge rrst_n) begin
        if (!rrst_n) begin
            rptr_q      <= '0;
            r_gray_q    <= '0;
            out_valid_q <= 1'b0;
            // NOTE: the data register is reset too, so a word held across reset never resurfaces.
            out_data_q  <= '0;
        end else begin
            rptr_q      <= rptr_d;
            r_gray_q    <= r_gray_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    assign bus.raddr      = rptr_q[ADDR_W-1:0];
    assign bus.r_gray_ptr = r_gray_q;
    assign bus.rempty     = rempty;
    assign bus.r_level    = rq2_bin - rptr_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_data   = out_data_q;

endmodule
